wb_gpio_multi: RTL and testbench
================================

WB_GPIO_MULTI -- requirements
Module: wb_gpio_multi

Interface
REQ-001 SHALL have parameter GW, default 8: GPIO channel count, legal range 1..32.
REQ-002 SHALL have parameter AW, default 32: Wishbone address width.
REQ-003 SHALL have parameter DW, default 32: Wishbone data width.
REQ-004 SHALL have parameter SW, default DW>>3: byte-select width.
REQ-005 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, minimum 2.
REQ-006 SHALL have port clk, input, 1: clock, all logic rising-edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port gpio_i, input, GW: asynchronous pad inputs.
REQ-009 SHALL have port gpio_o, output, GW: pad output values.
REQ-010 SHALL have port gpio_oe, output, GW: pad output enables, 1 = drive.
REQ-011 SHALL have port irq_o, output, 1: level interrupt request.
REQ-012 SHALL have port i_wb_adr, input, AW: word address.
REQ-013 SHALL have port i_wb_sel, input, SW: byte lane selects.
REQ-014 SHALL have port i_wb_we, input, 1: write enable.
REQ-015 SHALL have port i_wb_dat, input, DW: write data.
REQ-016 SHALL have port o_wb_dat, output, DW: read data.
REQ-017 SHALL have port i_wb_cyc, input, 1: cycle.
REQ-018 SHALL have port i_wb_stb, input, 1: strobe.
REQ-019 SHALL have port o_wb_ack, output, 1: normal termination.
REQ-020 SHALL have port o_wb_err, output, 1: error termination.

Function
REQ-021 SHALL decode i_wb_adr[4:2] only: 0 OUT (RW), 1 IN (RO), 2 DIR (RW), 3 IRQ_EN (RW), 4 IRQ_STAT (W1C), 5 IRQ_EDGE (RW, 1 = rising, 0 = falling), 6..7 unmapped.
REQ-022 SHALL accept a request when i_wb_cyc & i_wb_stb and no response is pending, and SHALL register exactly one single-cycle response (ack or err) on the next cycle; no request is accepted in the response cycle, so each access occupies 2 cycles.
REQ-023 SHALL commit writes on the response edge; only bytes with i_wb_sel set are updated; bits at and above GW are ignored.
REQ-024 SHALL present read data registered, valid only in the ack cycle, zero otherwise; bits at and above GW read 0.
REQ-025 SHALL signal o_wb_err instead of o_wb_ack for unmapped offsets, with no state change and read data 0.
REQ-026 SHALL ack writes to IN with no effect.
REQ-027 SHALL drive gpio_o = OUT and gpio_oe = DIR.
REQ-028 SHALL pass gpio_i through SYNC_STAGES flops; IN returns the synchronised value, so latency from pad to IN is SYNC_STAGES cycles.
REQ-029 SHALL detect an edge per bit by comparing the synchronised value against its one-cycle-delayed copy, with polarity selected by IRQ_EDGE, and SHALL set the matching IRQ_STAT bit regardless of IRQ_EN.
REQ-030 SHALL clear IRQ_STAT bits written with 1; a new edge in the same cycle as a clear SHALL win, leaving the bit set.
REQ-031 SHALL drive irq_o registered: irq_o = |(IRQ_STAT & IRQ_EN), 1-cycle latency.
REQ-032 SHALL abort a pending response if i_wb_cyc falls before the response is issued; the write is not committed.

Reset
REQ-033 SHALL on rst_n low asynchronously clear OUT, DIR, IRQ_EN, IRQ_STAT, IRQ_EDGE, the synchroniser/delay flops, the response state, o_wb_ack, o_wb_err, o_wb_dat and irq_o to 0.
REQ-034 SHALL not report an edge on the first cycles after reset: the delay flop tracks the synchroniser from reset.

Configuration
REQ-035 SHALL include interrupt logic (offsets 3..5, edge detect, irq_o) only when macro WB_GPIO_MULTI_IRQ_EN is defined.
REQ-036 SHALL, without WB_GPIO_MULTI_IRQ_EN, ack offsets 3..5 with read data 0, ignore writes to them, and tie irq_o to 0.

Structure
REQ-037 SHALL take register offset constants and the IRQ_EDGE encoding from shared package wb_gpio_pkg.
REQ-038 SHALL instantiate sub-module gpio_sync (per-bit synchroniser plus rising/falling edge pulses), parameterised by GW and SYNC_STAGES.

Verification
REQ-039 SHALL cover: write OUT=0xA5 with sel=0x1, DIR=0xFF -> ack 1 cycle after request, gpio_o=0xA5, gpio_oe=0xFF.
REQ-040 SHALL cover: gpio_i=0x3C held -> IN reads 0x3C no earlier than 2 cycles after change; upper 24 bits read 0.
REQ-041 SHALL cover: IRQ_EDGE=0x01, IRQ_EN=0x01, gpio_i[0] 0->1 -> IRQ_STAT=0x01, irq_o=1; W1C 0x01 -> irq_o=0 one cycle later.
REQ-042 SHALL cover: W1C on bit 0 coinciding with a new rising edge on bit 0 -> IRQ_STAT bit 0 stays 1.
REQ-043 SHALL cover: access to offset 6 (byte address 0x18) -> o_wb_err=1, o_wb_ack=0, no register change.
REQ-044 SHALL cover: rst_n asserted mid-access -> all outputs 0 immediately, and no spurious irq after release.

Source files
------------

// File: rtl/wb_gpio_pkg.sv
// wb_gpio_pkg: register offsets and IRQ_EDGE polarity encoding shared by the GPIO block.
package wb_gpio_pkg;
    localparam logic [2:0] OFF_OUT   = 3'd0;
    localparam logic [2:0] OFF_IN    = 3'd1;
    localparam logic [2:0] OFF_DIR   = 3'd2;
    localparam logic [2:0] OFF_IEN   = 3'd3;
    localparam logic [2:0] OFF_IST   = 3'd4;
    localparam logic [2:0] OFF_IEDGE = 3'd5;
    localparam logic       EDGE_RISE = 1'b1;
    localparam logic       EDGE_FALL = 1'b0;
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: per-bit pad synchroniser with one-cycle delay copy and rising/falling edge pulses.
module gpio_sync #(
    parameter int GW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [GW-1:0] i_d,
    output logic [GW-1:0] o_q,
    output logic [GW-1:0] o_rise,
    output logic [GW-1:0] o_fall
);
    logic [SYNC_STAGES-1:0][GW-1:0] r_sync;
    logic [GW-1:0]                  r_dly;
    logic [SYNC_STAGES:0]           r_vld;
    logic [GW-1:0]                  w_en;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_sync <= '0;
            r_dly  <= '0;
            r_vld  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_dly  <= r_sync[SYNC_STAGES-1];
            r_vld  <= {r_vld[SYNC_STAGES-1:0], 1'b1};
        end

    // Edges are masked until both the synchroniser and the delay copy hold real pad samples.
    assign w_en   = {GW{r_vld[SYNC_STAGES]}};
    assign o_q    = r_sync[SYNC_STAGES-1];
    assign o_rise = w_en & o_q & ~r_dly;
    assign o_fall = w_en & ~o_q & r_dly;
endmodule

// File: rtl/wb_gpio_multi.sv
// wb_gpio_multi: Wishbone GPIO block with OUT/IN/DIR registers.
// Define WB_GPIO_MULTI_IRQ_EN to add edge interrupts (IRQ_EN, IRQ_STAT, IRQ_EDGE, irq_o).
module wb_gpio_multi
    import wb_gpio_pkg::*;
#(
    parameter int GW          = 8,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int SW          = DW >> 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [GW-1:0] gpio_i,
    output logic [GW-1:0] gpio_o,
    output logic [GW-1:0] gpio_oe,
    output logic          irq_o,
    input  logic [AW-1:0] i_wb_adr,
    input  logic [SW-1:0] i_wb_sel,
    input  logic          i_wb_we,
    input  logic [DW-1:0] i_wb_dat,
    output logic [DW-1:0] o_wb_dat,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    output logic          o_wb_ack,
    output logic          o_wb_err
);
    logic [GW-1:0] w_sync, w_rise, w_fall, w_wd, w_mask, r_out, r_dir;
    logic [DW-1:0] w_rd, r_dat;
    logic [2:0]    w_off;
    logic          w_acc, w_bad, w_wr, r_ack, r_err, w_unused;

    gpio_sync #(.GW(GW), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (gpio_i),
        .o_q    (w_sync),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_off = i_wb_adr[4:2];
    assign w_acc = i_wb_cyc & i_wb_stb & ~r_ack & ~r_err;
    assign w_bad = w_off > OFF_IEDGE;
    assign w_wr  = w_acc & ~w_bad & i_wb_we;
    assign w_wd  = i_wb_dat[GW-1:0];

    genvar i;
    for (i = 0; i < GW; i++) begin : g_mask
        assign w_mask[i] = i_wb_sel[i/8];
    end

    function automatic logic [GW-1:0] f_upd(input logic [GW-1:0] q);
        return (q & ~w_mask) | (w_wd & w_mask);
    endfunction

`ifdef WB_GPIO_MULTI_IRQ_EN
    logic [GW-1:0] r_ien, r_ist, r_edge, w_hit, w_clr;
    logic          r_irq;

    for (i = 0; i < GW; i++) begin : g_hit
        assign w_hit[i] = (r_edge[i] == EDGE_RISE) ? w_rise[i] : w_fall[i];
    end

    assign w_clr = (w_wr && w_off == OFF_IST) ? (w_wd & w_mask) : '0;

    // A fresh edge is ORed in after the clear so it survives a coincident W1C.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_ien  <= '0;
            r_ist  <= '0;
            r_edge <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && w_off == OFF_IEN) r_ien <= f_upd(r_ien);
            if (w_wr && w_off == OFF_IEDGE) r_edge <= f_upd(r_edge);
            r_ist <= (r_ist & ~w_clr) | w_hit;
            r_irq <= |(r_ist & r_ien);
        end

    assign irq_o    = r_irq;
    assign w_unused = &{1'b0, i_wb_adr, i_wb_dat, i_wb_sel};
`else
    assign irq_o    = 1'b0;
    assign w_unused = &{1'b0, i_wb_adr, i_wb_dat, i_wb_sel, w_rise, w_fall};
`endif

    always_comb begin
        w_rd = '0;
        case (w_off)
            OFF_OUT:   w_rd = DW'(r_out);
            OFF_IN:    w_rd = DW'(w_sync);
            OFF_DIR:   w_rd = DW'(r_dir);
`ifdef WB_GPIO_MULTI_IRQ_EN
            OFF_IEN:   w_rd = DW'(r_ien);
            OFF_IST:   w_rd = DW'(r_ist);
            OFF_IEDGE: w_rd = DW'(r_edge);
`endif
            default:   w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
            r_out <= '0;
            r_dir <= '0;
        end else begin
            r_ack <= w_acc & ~w_bad;
            r_err <= w_acc & w_bad;
            r_dat <= (w_acc & ~w_bad & ~i_wb_we) ? w_rd : '0;
            if (w_wr && w_off == OFF_OUT) r_out <= f_upd(r_out);
            if (w_wr && w_off == OFF_DIR) r_dir <= f_upd(r_dir);
        end

    assign gpio_o   = r_out;
    assign gpio_oe  = r_dir;
    assign o_wb_ack = r_ack;
    assign o_wb_err = r_err;
    assign o_wb_dat = r_dat;
endmodule

// File: tb/tb_wb_gpio_multi.sv
// tb_wb_gpio_multi: directed bench for wb_gpio_multi; expectations follow WB_GPIO_MULTI_IRQ_EN.
module tb_wb_gpio_multi;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  gpio_i = '0;
    logic [7:0]  gpio_o, gpio_oe;
    logic        irq_o;
    logic [31:0] adr = '0, wdat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack, o_wb_err;

    typedef struct {
        string       tag;
        logic [1:0]  resp;
        logic [31:0] dat;
        logic        dchk;
    } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_pass = 0, n_fail = 0;

    wb_gpio_multi dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gpio_i   (gpio_i),
        .gpio_o   (gpio_o),
        .gpio_oe  (gpio_oe),
        .irq_o    (irq_o),
        .i_wb_adr (adr),
        .i_wb_sel (sel),
        .i_wb_we  (we),
        .i_wb_dat (wdat),
        .o_wb_dat (o_wb_dat),
        .i_wb_cyc (cyc),
        .i_wb_stb (stb),
        .o_wb_ack (o_wb_ack),
        .o_wb_err (o_wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic w, input logic [4:0] badr, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] resp, input logic [31:0] rd, input logic dchk);
        exp_t e;
        sb.push_back('{tag, resp, rd, dchk});
        adr = {27'b0, badr};
        we = w;
        wdat = d;
        sel = s;
        cyc = 1'b1;
        stb = 1'b1;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".resp"}, {30'b0, o_wb_ack, o_wb_err}, {30'b0, e.resp});
        if (e.dchk) chk({e.tag, ".dat"}, o_wb_dat, e.dat);
        cyc = 1'b0;
        stb = 1'b0;
        we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic [4:0] badr, input logic [31:0] d, input logic [3:0] s);
        xfer(tag, 1'b1, badr, d, s, 2'b10, 32'h0, 1'b0);
    endtask

    task automatic rd(input string tag, input logic [4:0] badr, input logic [31:0] exp);
        xfer(tag, 1'b0, badr, 32'h0, 4'hF, 2'b10, exp, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pins", {15'b0, irq_o, gpio_o, gpio_oe}, 32'h0);
        chk("rst_bus", {30'b0, o_wb_ack, o_wb_err}, 32'h0);
        chk("rst_dat", o_wb_dat, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        wr("out_a5", 5'h00, 32'hFFFF_FFA5, 4'h1);
        chk("ack_one_cycle", {30'b0, o_wb_ack, o_wb_err}, 32'h0);
        wr("dir_ff", 5'h08, 32'h0000_00FF, 4'hF);
        chk("pins", {16'b0, gpio_o, gpio_oe}, 32'h0000_A5FF);
        wr("out_sel0", 5'h00, 32'h0000_0000, 4'h0);
        rd("out_rd", 5'h00, 32'h0000_00A5);
        rd("dir_rd", 5'h08, 32'h0000_00FF);

        gpio_i = 8'h3C;
        rd("in_early", 5'h04, 32'h0);
        rd("in_sync", 5'h04, 32'h0000_003C);
        wr("in_wr", 5'h04, 32'hFFFF_FFFF, 4'hF);
        rd("in_ro", 5'h04, 32'h0000_003C);

        xfer("off6_wr", 1'b1, 5'h18, 32'h0, 4'hF, 2'b01, 32'h0, 1'b1);
        xfer("off7_rd", 1'b0, 5'h1C, 32'h0, 4'hF, 2'b01, 32'h0, 1'b1);
        rd("dir_after_err", 5'h08, 32'h0000_00FF);
        rd("out_after_err", 5'h00, 32'h0000_00A5);

        adr = 32'h0;
        we = 1'b1;
        wdat = 32'h0;
        sel = 4'hF;
        cyc = 1'b1;
        stb = 1'b1;
        #2;
        cyc = 1'b0;
        stb = 1'b0;
        we = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_resp", {30'b0, o_wb_ack, o_wb_err}, 32'h0);
        rd("abort_out", 5'h00, 32'h0000_00A5);

`ifdef WB_GPIO_MULTI_IRQ_EN
        wr("edge_wr", 5'h14, 32'h1, 4'hF);
        wr("ien_wr", 5'h0C, 32'h1, 4'hF);
        rd("edge_rd", 5'h14, 32'h1);
        rd("ist_idle", 5'h10, 32'h0);
        gpio_i = 8'h3D;
        repeat (4) @(posedge clk);
        #1;
        rd("ist_set", 5'h10, 32'h1);
        chk("irq_hi", {31'b0, irq_o}, 32'h1);
        wr("ist_w1c", 5'h10, 32'h1, 4'h1);
        chk("irq_lo", {31'b0, irq_o}, 32'h0);
        rd("ist_clr", 5'h10, 32'h0);
        gpio_i = 8'h3C;
        repeat (4) @(posedge clk);
        #1;
        rd("ist_fall_ignored", 5'h10, 32'h0);
        gpio_i = 8'h3D;
        @(posedge clk);
        @(posedge clk);
        #1;
        wr("w1c_race", 5'h10, 32'h1, 4'h1);
        rd("ist_race", 5'h10, 32'h1);
        chk("irq_race", {31'b0, irq_o}, 32'h1);
        wr("edge_fall", 5'h14, 32'h0, 4'hF);
        wr("ist_w1c_all", 5'h10, 32'hFF, 4'hF);
        gpio_i = 8'h3C;
        repeat (4) @(posedge clk);
        #1;
        rd("ist_fall", 5'h10, 32'h1);
`else
        wr("ien_wr", 5'h0C, 32'hFF, 4'hF);
        wr("edge_wr", 5'h14, 32'hFF, 4'hF);
        rd("ien_rd", 5'h0C, 32'h0);
        rd("edge_rd", 5'h14, 32'h0);
        gpio_i = 8'h3D;
        repeat (4) @(posedge clk);
        #1;
        rd("ist_rd", 5'h10, 32'h0);
        chk("irq_off", {31'b0, irq_o}, 32'h0);
`endif

        adr = 32'h0;
        sel = 4'hF;
        cyc = 1'b1;
        stb = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_ack", {30'b0, o_wb_ack, o_wb_err}, 32'h2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pins", {15'b0, irq_o, gpio_o, gpio_oe}, 32'h0);
        chk("mid_rst_bus", {30'b0, o_wb_ack, o_wb_err}, 32'h0);
        chk("mid_rst_dat", o_wb_dat, 32'h0);
        cyc = 1'b0;
        stb = 1'b0;
        gpio_i = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_irq", {31'b0, irq_o}, 32'h0);
        wr("post_rst_ien", 5'h0C, 32'hFF, 4'hF);
        rd("post_rst_ist", 5'h10, 32'h0);
        chk("post_rst_irq2", {31'b0, irq_o}, 32'h0);
        rd("post_rst_out", 5'h00, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
